// File: rtl/enc_8to3_rr.sv
// 8-to-3 request encoder with a hold/accept handshake on its registered output.
// Define ENC_ROUND_ROBIN_EN for rotating-pointer arbitration; otherwise the lowest set index wins.
module enc_8to3_rr (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       en,
  input  logic       ack,
  output logic [2:0] y,
  output logic [7:0] grant,
  output logic       valid
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0] state_reg, state_next;
  logic [2:0] y_reg, y_next;
  logic [7:0] grant_reg, grant_next;
  logic       valid_reg, valid_next;

  logic [7:0] scan_req;
  logic [2:0] win_off;
  logic [2:0] winner;
  logic [7:0] winner_onehot;
  logic       any_req;
  logic       issue;

`ifdef ENC_ROUND_ROBIN_EN
  logic [2:0] ptr_reg, ptr_next;

  // Rotate the requests so the pointer position lands at bit 0; the encoder
  // below then only needs a fixed lowest-index search.
  for (genvar gi = 0; gi < 8; gi++) begin : g_rot
    assign scan_req[gi] = req[ptr_reg + 3'(gi)];
  end

  assign winner   = win_off + ptr_reg;
  assign ptr_next = issue ? (winner + 3'd1) : ptr_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg <= 3'd0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end
`else
  assign scan_req = req;
  assign winner   = win_off;
`endif

  always_comb begin
    win_off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (scan_req[i]) begin
        win_off = 3'(i);
      end
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_dec
    assign winner_onehot[gi] = (winner == 3'(gi));
  end

  assign any_req = |req;
  // A new grant may only be issued when the output slot is free or being accepted now.
  assign issue   = en && any_req && ((state_reg == IDLE) || ack);

  always_comb begin
    state_next = state_reg;
    y_next     = y_reg;
    grant_next = grant_reg;
    valid_next = valid_reg;
    case (state_reg)
      IDLE: begin
        if (issue) begin
          state_next = HOLD;
          y_next     = winner;
          grant_next = winner_onehot;
          valid_next = 1'b1;
        end
      end
      HOLD: begin
        if (ack) begin
          if (issue) begin
            y_next     = winner;
            grant_next = winner_onehot;
          end else begin
            state_next = IDLE;
            y_next     = 3'd0;
            grant_next = 8'h00;
            valid_next = 1'b0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        y_next     = 3'd0;
        grant_next = 8'h00;
        valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      y_reg     <= 3'd0;
      grant_reg <= 8'h00;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      y_reg     <= y_next;
      grant_reg <= grant_next;
      valid_reg <= valid_next;
    end
  end

  assign y     = y_reg;
  assign grant = grant_reg;
  assign valid = valid_reg;

endmodule

// File: tb/tb_enc_8to3_rr.sv
// Scoreboard bench for enc_8to3_rr: a reference model predicts each cycle's
// outputs, which are queued when inputs are driven and compared after the edge.
module tb_enc_8to3_rr;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic       en;
  logic       ack;
  logic [2:0] y;
  logic [7:0] grant;
  logic       valid;

  int checks;
  int errors;

  // Reference model state
  logic       m_valid;
  logic [2:0] m_y;
  logic [2:0] m_ptr;

  logic [11:0] exp_q[$];

  enc_8to3_rr dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .en    (en),
    .ack   (ack),
    .y     (y),
    .grant (grant),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] model_winner(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    logic [2:0] w;
    logic       found;
    w     = 3'd0;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
`ifdef ENC_ROUND_ROBIN_EN
      idx = p + 3'(k);
`else
      idx = 3'(k);
`endif
      if (!found && r[idx]) begin
        w     = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  // Drive one cycle of stimulus, predict the post-edge outputs, compare them.
  task automatic step(input string tag, input logic rst, input logic e,
                      input logic [7:0] r, input logic a);
    logic [2:0]  w;
    logic [11:0] exp_v;
    logic [11:0] got_v;
    logic [7:0]  exp_g;
    @(negedge clk);
    reset = rst;
    en    = e;
    req   = r;
    ack   = a;
    if (rst) begin
      m_valid = 1'b0;
      m_y     = 3'd0;
      m_ptr   = 3'd0;
    end else if (e && (r != 8'h00) && (!m_valid || a)) begin
      w       = model_winner(r, m_ptr);
      m_valid = 1'b1;
      m_y     = w;
`ifdef ENC_ROUND_ROBIN_EN
      m_ptr   = w + 3'd1;
`endif
    end else if (m_valid && a) begin
      m_valid = 1'b0;
      m_y     = 3'd0;
    end
    exp_g = m_valid ? (8'h01 << m_y) : 8'h00;
    exp_q.push_back({m_valid, exp_g, m_y});
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    got_v = {valid, grant, y};
    $display("txn %-10s rst=%b en=%b req=%h ack=%b -> valid=%b y=%0d grant=%h",
             tag, rst, e, r, a, valid, y, grant);
    chk({tag, "_out"}, 32'(got_v), 32'(exp_v));
    chk({tag, "_1hot"}, 32'($countones(grant) <= 1), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

  initial begin
    checks  = 0;
    errors  = 0;
    m_valid = 1'b0;
    m_y     = 3'd0;
    m_ptr   = 3'd0;
    reset   = 1'b1;
    en      = 1'b0;
    req     = 8'h00;
    ack     = 1'b0;

    step("reset", 1'b1, 1'b1, 8'hFF, 1'b1);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_grant", 32'(grant), 32'h00);

    // Single grant held while req changes underneath
    step("r25_issue", 1'b0, 1'b1, 8'h24, 1'b0);
    chk("r25_y", 32'(y), 32'd2);
    chk("r25_grant", 32'(grant), 32'h04);
    for (int i = 0; i < 5; i++) step("r25_hold", 1'b0, 1'b1, 8'h80, 1'b0);
    chk("r25_held_y", 32'(y), 32'd2);

    // Continuous all-requests with ack every cycle
    step("rst", 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step("allreq", 1'b0, 1'b1, 8'hFF, 1'b1);
`ifdef ENC_ROUND_ROBIN_EN
      chk("r26_y", 32'(y), 32'(i % 8));
`else
      chk("r27_y", 32'(y), 32'd0);
`endif
      chk("allreq_valid", 32'(valid), 32'd1);
    end
    step("upper", 1'b0, 1'b1, 8'hF0, 1'b1);
`ifndef ENC_ROUND_ROBIN_EN
    chk("r27_f0", 32'(y), 32'd4);
`endif

    // Accept with no further requests returns to idle
    step("rst", 1'b1, 1'b0, 8'h00, 1'b0);
    step("r28_y5", 1'b0, 1'b1, 8'h20, 1'b0);
    chk("r28_y", 32'(y), 32'd5);
    step("r28_drop", 1'b0, 1'b1, 8'h00, 1'b1);
    chk("r28_valid", 32'(valid), 32'd0);
    chk("r28_grant", 32'(grant), 32'h00);

    // Enable gating
    for (int i = 0; i < 3; i++) step("r29_en0", 1'b0, 1'b0, 8'h01, 1'b0);
    chk("r29_idle", 32'(valid), 32'd0);
    step("r29_en1", 1'b0, 1'b1, 8'h01, 1'b0);
    chk("r29_y", 32'(y), 32'd0);
    step("en0_ack", 1'b0, 1'b0, 8'hFF, 1'b1);
    chk("en0_ack_valid", 32'(valid), 32'd0);

    // Reset while holding an unaccepted grant
    step("rst", 1'b1, 1'b0, 8'h00, 1'b0);
    step("r30_y6", 1'b0, 1'b1, 8'h40, 1'b0);
    chk("r30_y6", 32'(y), 32'd6);
    step("r30_rst", 1'b1, 1'b1, 8'hC0, 1'b0);
    chk("r30_rst_valid", 32'(valid), 32'd0);
    step("r30_rel", 1'b0, 1'b1, 8'hC0, 1'b0);
    chk("r30_y", 32'(y), 32'd6);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           8'($urandom), ($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
